// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: retires ALU, link and load results into the
// register file, waiting on data memory with a bounded load timeout.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        InValid,
  input  logic [4:0]  InRd,
  input  logic [63:0] InAlu,
  input  logic [63:0] InPC,
  input  logic        InIsLoad,
  input  logic        InIsLink,
  input  logic        InRegWrite,
  input  logic        Flush,
  input  logic [63:0] MemData,
  input  logic        MemRdy,
  output logic        Stall,
  output logic [4:0]  WReg,
  output logic [63:0] Data,
  output logic        WE,
  output logic        MemErr,
  output logic [15:0] RetCount
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    ERR       = 2'd2
  } state_e;

  localparam logic [4:0] XZR  = 5'd31;
  localparam logic [4:0] LINK = 5'd30;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        we_q, we_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;
  logic [15:0] ret_q, ret_d;
  logic        accept;
  logic        retire;

  assign accept = (state_q == IDLE) && InValid && !Flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    data_d  = data_q;
    err_d   = err_q;
    retire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (InIsLink) begin
            retire = 1'b1;
            we_d   = 1'b1;
            wreg_d = LINK;
            data_d = InPC + 64'd4;
          end else if (InIsLoad) begin
            state_d = LOAD_WAIT;
            cnt_d   = 8'd0;
            rd_d    = InRd;
            rw_d    = InRegWrite;
          end else begin
            retire = 1'b1;
            if (InRegWrite && InRd != XZR) begin
              we_d   = 1'b1;
              wreg_d = InRd;
              data_d = InAlu;
            end
          end
        end
      end
      LOAD_WAIT: begin
        // flush beats a same-cycle MemRdy; MemRdy beats the timeout
        if (Flush) begin
          state_d = IDLE;
        end else if (MemRdy) begin
          state_d = IDLE;
          retire  = 1'b1;
          if (rw_q && rd_q != XZR) begin
            we_d   = 1'b1;
            wreg_d = rd_q;
            data_d = MemData;
          end
        end else if (cnt_q == LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ret_d = ret_q;
    if (retire && ret_q != 16'hFFFF) begin
      ret_d = ret_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= 5'd0;
      data_q  <= 64'd0;
      err_q   <= 1'b0;
      ret_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
    end
  end

  assign Stall    = (state_q != IDLE);
  assign WReg     = wreg_q;
  assign Data     = data_q;
  assign WE       = we_q;
  assign MemErr   = err_q;
  assign RetCount = ret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected writes queued at stimulus,
// popped by a negedge monitor whenever WE is seen.
module tb_mem_wb_stage;

  logic        Clk;
  logic        Rst;
  logic        InValid;
  logic [4:0]  InRd;
  logic [63:0] InAlu;
  logic [63:0] InPC;
  logic        InIsLoad;
  logic        InIsLink;
  logic        InRegWrite;
  logic        Flush;
  logic [63:0] MemData;
  logic        MemRdy;
  logic        Stall;
  logic [4:0]  WReg;
  logic [63:0] Data;
  logic        WE;
  logic        MemErr;
  logic [15:0] RetCount;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
  } wr_t;

  wr_t sb[$];
  int  checks;
  int  failures;
  int  exp_ret;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InRd(InRd),
    .InAlu(InAlu), .InPC(InPC), .InIsLoad(InIsLoad),
    .InIsLink(InIsLink), .InRegWrite(InRegWrite), .Flush(Flush),
    .MemData(MemData), .MemRdy(MemRdy), .Stall(Stall), .WReg(WReg),
    .Data(Data), .WE(WE), .MemErr(MemErr), .RetCount(RetCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (WE === 1'b1) begin
      wr_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_we: WReg=%0d Data=%h, no write expected",
                 WReg, Data);
      end else begin
        e = sb.pop_front();
        if (WReg !== e.rd || Data !== e.d) begin
          failures++;
          $display("FAIL write: got WReg=%0d Data=%h, want WReg=%0d Data=%h",
                   WReg, Data, e.rd, e.d);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] pc,
                       input logic ld, input logic lk, input logic rw);
    InValid    = v;
    InRd       = rd;
    InAlu      = alu;
    InPC       = pc;
    InIsLoad   = ld;
    InIsLink   = lk;
    InRegWrite = rw;
  endtask

  task automatic drive_idle();
    drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    Flush   = 1'b0;
    MemRdy  = 1'b0;
    MemData = 64'd0;
  endtask

  task automatic drain(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes: %0d pending, want 0",
               name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    drive_idle();
    @(negedge Clk);
    checks++;
    if ({WE, Stall, MemErr} !== 3'b000 || WReg !== 5'd0 ||
        Data !== 64'd0 || RetCount !== 16'd0) begin
      failures++;
      $display("FAIL reset: WE=%b Stall=%b MemErr=%b WReg=%0d Data=%h Ret=%0d, want all 0",
               WE, Stall, MemErr, WReg, Data, RetCount);
    end
    Rst = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_alu();
    @(negedge Clk);
    drive(1'b1, 5'd5, 64'h1234, 64'h100, 1'b0, 1'b0, 1'b1);
    sb.push_back('{5'd5, 64'h1234});
    exp_ret++;
    @(negedge Clk);
    drive_idle();
    checks++;
    if (WE !== 1'b1 || RetCount !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL alu_we: WE=%b Ret=%0d, want WE=1 Ret=%0d",
               WE, RetCount, exp_ret);
    end
    @(negedge Clk);
    checks++;
    if (WE !== 1'b0 || WReg !== 5'd5 || Data !== 64'h1234) begin
      failures++;
      $display("FAIL alu_hold: WE=%b WReg=%0d Data=%h, want 0/5/1234",
               WE, WReg, Data);
    end
    drain("alu");
  endtask

  task automatic test_link();
    @(negedge Clk);
    drive(1'b1, 5'd3, 64'hBAD, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b0);
    sb.push_back('{5'd30, 64'h0});
    exp_ret++;
    @(negedge Clk);
    drive_idle();
    checks++;
    if (WE !== 1'b1 || Stall !== 1'b0 || RetCount !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL link: WE=%b Stall=%b Ret=%0d, want 1/0/%0d",
               WE, Stall, RetCount, exp_ret);
    end
    @(negedge Clk);
    drain("link");
  endtask

  task automatic test_load();
    @(negedge Clk);
    drive(1'b1, 5'd7, 64'h55, 64'h0, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      drive_idle();
      checks++;
      if (Stall !== 1'b1 || WE !== 1'b0) begin
        failures++;
        $display("FAIL load_wait%0d: Stall=%b WE=%b, want 1/0",
                 c, Stall, WE);
      end
      if (c == 3) begin
        MemRdy  = 1'b1;
        MemData = 64'hDEAD;
        sb.push_back('{5'd7, 64'hDEAD});
        exp_ret++;
      end
    end
    @(negedge Clk);
    drive_idle();
    checks++;
    if (WE !== 1'b1 || Stall !== 1'b0 || RetCount !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL load_done: WE=%b Stall=%b Ret=%0d, want 1/0/%0d",
               WE, Stall, RetCount, exp_ret);
    end
    @(negedge Clk);
    drain("load");
  endtask

  task automatic test_back_to_back();
    logic [4:0] rds[5];
    logic       rws[5];
    rds = '{5'd1, 5'd31, 5'd2, 5'd9, 5'd3};
    rws = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (i > 0) begin
        checks++;
        if (Stall !== 1'b0) begin
          failures++;
          $display("FAIL b2b_stall%0d: Stall=%b, want 0", i, Stall);
        end
      end
      drive(1'b1, rds[i], 64'hA000 + 64'(i), 64'h0, 1'b0, 1'b0, rws[i]);
      if (rws[i] && rds[i] != 5'd31) begin
        sb.push_back('{rds[i], 64'hA000 + 64'(i)});
      end
      exp_ret++;
    end
    @(negedge Clk);
    drive_idle();
    @(negedge Clk);
    checks++;
    if (RetCount !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL b2b_retcount: got %0d, want %0d", RetCount, exp_ret);
    end
    drain("b2b");
  endtask

  task automatic test_xzr_flush();
    @(negedge Clk);
    drive(1'b1, 5'd31, 64'h77, 64'h0, 1'b0, 1'b0, 1'b1);
    exp_ret++;
    @(negedge Clk);
    drive(1'b1, 5'd9, 64'h99, 64'h0, 1'b0, 1'b0, 1'b1);
    Flush = 1'b1;
    checks++;
    if (WE !== 1'b0 || RetCount !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL xzr: WE=%b Ret=%0d, want 0/%0d", WE, RetCount, exp_ret);
    end
    @(negedge Clk);
    drive_idle();
    MemRdy  = 1'b1;
    MemData = 64'hF00D;
    @(negedge Clk);
    drive(1'b1, 5'd11, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (WE !== 1'b0 || RetCount !== 16'(exp_ret) || Stall !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore: WE=%b Ret=%0d Stall=%b, want 0/%0d/0",
               WE, RetCount, Stall, exp_ret);
    end
    @(negedge Clk);
    drive_idle();
    Flush   = 1'b1;
    MemRdy  = 1'b1;
    MemData = 64'hBEEF;
    @(negedge Clk);
    drive_idle();
    checks++;
    if (WE !== 1'b0 || Stall !== 1'b0 || RetCount !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL load_flush: WE=%b Stall=%b Ret=%0d, want 0/0/%0d",
               WE, Stall, RetCount, exp_ret);
    end
    @(negedge Clk);
    drain("xzr_flush");
  endtask

  task automatic test_timeout();
    @(negedge Clk);
    drive(1'b1, 5'd8, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clk);
      drive_idle();
      checks++;
      if (Stall !== 1'b1 || MemErr !== (c == 5)) begin
        failures++;
        $display("FAIL timeout_c%0d: Stall=%b MemErr=%b, want 1/%b",
                 c, Stall, MemErr, c == 5);
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd4, 64'h1, 64'h0, 1'b0, 1'b0, 1'b1);
      Flush  = (c == 0);
      MemRdy = 1'b1;
      @(negedge Clk);
      checks++;
      if (Stall !== 1'b1 || MemErr !== 1'b1 || WE !== 1'b0) begin
        failures++;
        $display("FAIL err_hold%0d: Stall=%b MemErr=%b WE=%b, want 1/1/0",
                 c, Stall, MemErr, WE);
      end
    end
    drive_idle();
    #2 Rst = 1'b0;
    #1;
    checks++;
    if ({Stall, MemErr, WE} !== 3'b000 || RetCount !== 16'd0 ||
        WReg !== 5'd0 || Data !== 64'd0) begin
      failures++;
      $display("FAIL err_reset: Stall=%b MemErr=%b WE=%b Ret=%0d, want 0s",
               Stall, MemErr, WE, RetCount);
    end
    exp_ret = 0;
    @(negedge Clk);
    Rst = 1'b1;
    drain("timeout");
  endtask

  task automatic test_reset_mid_load();
    @(negedge Clk);
    drive(1'b1, 5'd10, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);
    @(negedge Clk);
    drive_idle();
    #2 Rst = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b0 || WE !== 1'b0 || RetCount !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset: Stall=%b WE=%b Ret=%0d, want 0/0/0",
               Stall, WE, RetCount);
    end
    @(negedge Clk);
    Rst     = 1'b1;
    MemRdy  = 1'b1;
    MemData = 64'h5555;
    @(negedge Clk);
    drive_idle();
    checks++;
    if (WE !== 1'b0 || Stall !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_memrdy: WE=%b Stall=%b, want 0/0", WE, Stall);
    end
    #2 Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    drive(1'b1, 5'd12, 64'hC0DE, 64'h0, 1'b0, 1'b0, 1'b1);
    sb.push_back('{5'd12, 64'hC0DE});
    exp_ret = 1;
    @(negedge Clk);
    drive_idle();
    checks++;
    if (WE !== 1'b1 || RetCount !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL first_accept: WE=%b Ret=%0d, want 1/%0d",
               WE, RetCount, exp_ret);
    end
    @(negedge Clk);
    drain("mid_reset");
  endtask

  task automatic test_saturate();
    @(negedge Clk);
    drive(1'b1, 5'd31, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    repeat (65540 - exp_ret) @(negedge Clk);
    drive_idle();
    @(negedge Clk);
    checks++;
    if (RetCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturate: RetCount=%h, want FFFF", RetCount);
    end
    drain("saturate");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_ret  = 0;
    test_reset();
    test_alu();
    test_link();
    test_load();
    test_back_to_back();
    test_xzr_flush();
    test_timeout();
    test_reset_mid_load();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
